hilo_ctrl: RTL and testbench
============================

Name: hilo_ctrl

Overview:
Sequencer and architectural HI/LO register pair sitting between the control unit and the multi-cycle multiply and divide units. Accepts mult/div/mthi/mtlo requests and latches the operands. Issues a one-cycle start to the selected unit, waits for its done level, then commits the 64-bit result into HI/LO. Drives a busy stall to the pipeline for the whole operation.

Parameters:
WIDTH, 32, operand and HI/LO width
TIMEOUT_CYCLES, 64, wait-cycle limit before abort (used only with HILO_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start_mult  in  1  request signed multiply of op_a*op_b
start_div  in  1  request signed divide op_a/op_b
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
wdata  in  WIDTH  mthi/mtlo data
mult_start  out  1  one-cycle start to multiplier
div_start  out  1  one-cycle start to divider
unit_a  out  WIDTH  latched operand A to both units
unit_b  out  WIDTH  latched operand B to both units
mult_done  in  1  multiplier done level; stays high until next start
mult_hi, mult_lo  in  WIDTH each  multiplier result
div_done  in  1  divider done level; same semantics as mult_done
div_hi, div_lo  in  WIDTH each  divider remainder / quotient
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on completion (commit, div-by-zero or timeout)
div_zero  out  1  one-cycle pulse with done when divisor was 0
timeout  out  1  one-cycle pulse with done on abort

Behaviour:
- Reset values: hi=0, lo=0, unit_a=0, unit_b=0, mult_start=0, div_start=0, done=0, div_zero=0, timeout=0, state=IDLE, wait counter=0.
- States: IDLE, M_ISSUE, M_WAIT, D_ISSUE, D_WAIT.
- IDLE: start_mult -> latch op_a/op_b into unit_a/unit_b, go to M_ISSUE.
- IDLE: start_div with op_b!=0 -> latch operands, go to D_ISSUE.
- IDLE: start_div with op_b==0 -> no issue, stay IDLE, hi/lo unchanged, done=1 and div_zero=1 next cycle.
- start_mult and start_div together in IDLE: multiply wins, start_div dropped.
- M_ISSUE/D_ISSUE: the matching mult_start/div_start is registered high for exactly this one cycle. Clear wait counter, then go to M_WAIT/D_WAIT. The done input is NOT sampled here, because a stale high level from the previous operation may still be present.
- M_WAIT/D_WAIT: the wait counter increments each cycle. On the matching done input=1, hi<=*_hi and lo<=*_lo, done pulses the next cycle, return to IDLE. The other unit's done input is ignored.
- unit_a/unit_b hold their values from latch until the next accept; changing op_a/op_b during busy has no effect.
- start_* while busy: ignored (the pipeline must stall on busy).
- mthi/mtlo: honoured only in IDLE, taking effect at the next edge. Dropped while busy.
- mthi/mtlo in the same cycle as an accepted start: the write happens; the later result commit overwrites it.
- mthi and mtlo together: both written with wdata.
- Latency: accept -> mult_start is 1 cycle; unit done seen -> hi/lo/done updated is 1 cycle. busy goes high the cycle after accept and drops in the same cycle done pulses.
- Reset mid-operation: immediately returns to IDLE with reset values. Any later done input is ignored until a new issue.

Optional Feature:
HILO_TIMEOUT_EN
- Defined: in M_WAIT/D_WAIT, if the wait counter reaches TIMEOUT_CYCLES without the done input, return to IDLE, hi/lo unchanged, done=1 and timeout=1 for one cycle.
- Not defined: the wait states wait indefinitely; timeout is tied 0; the counter is removed.

Test Plan:
- reset, then start_mult with op_a=7, op_b=0xFFFFFFFD; model asserts mult_done 32 cycles after mult_start with hi=0xFFFFFFFF, lo=0xFFFFFFEB -> mult_start high exactly 1 cycle, busy for the duration, hi/lo committed, done 1 cycle.
- Stale done: keep mult_done high from the previous op; issue a new mult; model drops done 1 cycle after mult_start and re-raises it after 32 cycles -> no commit before the re-raise.
- start_div with op_a=100, op_b=7; model returns div_hi=2, div_lo=14 -> hi=2, lo=14. Then start_div with op_b=0 -> no div_start, done=1 and div_zero=1 next cycle, hi=2 and lo=14 unchanged.
- mthi with wdata=0x1234 while busy -> ignored. mtlo with wdata=0x55 while IDLE -> lo=0x55 next cycle. start_mult and start_div together -> only mult_start pulses.
- reset asserted at cycle 10 of M_WAIT -> hi=lo=0, busy=0. A later mult_done=1 does not change hi/lo.
- With HILO_TIMEOUT_EN and TIMEOUT_CYCLES=64, mult_done never asserted -> timeout and done pulse after 64 wait cycles, hi/lo unchanged, busy=0.

Source files
------------

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register pair and mult/div sequencer; optional wait abort via HILO_TIMEOUT_EN
module hilo_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] wdata,
    output logic             mult_start,
    output logic             div_start,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             timeout
);
    typedef enum logic [2:0] {IDLE, M_ISSUE, M_WAIT, D_ISSUE, D_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
    logic             mult_start_q, mult_start_d, div_start_q, div_start_d;
    logic             done_q, done_d, div_zero_q, div_zero_d;

`ifdef HILO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;
    logic          wait_expired;
    // The abort fires on the edge that would bring the counter to TIMEOUT_CYCLES
    assign wait_expired = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        done_d       = 1'b0;
        div_zero_d   = 1'b0;
`ifdef HILO_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start_mult) begin
                    unit_a_d     = op_a;
                    unit_b_d     = op_b;
                    mult_start_d = 1'b1;
                    state_d      = M_ISSUE;
                end else if (start_div) begin
                    if (op_b == '0) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        unit_a_d    = op_a;
                        unit_b_d    = op_b;
                        div_start_d = 1'b1;
                        state_d     = D_ISSUE;
                    end
                end
            end
            // Done level may still be high from the previous op; not sampled here
            M_ISSUE: begin
                state_d = M_WAIT;
`ifdef HILO_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            D_ISSUE: begin
                state_d = D_WAIT;
`ifdef HILO_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            M_WAIT: begin
`ifdef HILO_TIMEOUT_EN
                wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                if (mult_done) begin
                    hi_d    = mult_hi;
                    lo_d    = mult_lo;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef HILO_TIMEOUT_EN
                else if (wait_expired) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            D_WAIT: begin
`ifdef HILO_TIMEOUT_EN
                wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                if (div_done) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef HILO_TIMEOUT_EN
                else if (wait_expired) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            done_q       <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            done_q       <= done_d;
            div_zero_q   <= div_zero_d;
        end
    end

`ifdef HILO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign mult_start = mult_start_q;
    assign div_start  = div_start_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign div_zero   = div_zero_q;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - randomized self-checking bench for hilo_ctrl with behavioural mult/div unit models
module tb_hilo_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0, start_div = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, wdata = '0;
    logic        mult_start, div_start;
    logic [31:0] unit_a, unit_b;
    logic        mult_done = 1'b0, div_done = 1'b0;
    logic [31:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero, timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    hilo_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .start_mult(start_mult), .start_div(start_div), .mthi(mthi), .mtlo(mtlo),
        .op_a(op_a), .op_b(op_b), .wdata(wdata),
        .mult_start(mult_start), .div_start(div_start), .unit_a(unit_a), .unit_b(unit_b),
        .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; the bench plays the unit whose done level stays high until the next start
    task automatic run_op(input bit is_div, input bit both, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit whi, input bit wlo, input logic [31:0] wd,
                          input bit busy_wr);
        logic [31:0] rh, rl;
        longint      p;
        int          qa, qb;
        start_mult = !is_div;
        start_div  = is_div | both;
        op_a = a; op_b = b; mthi = whi; mtlo = wlo; wdata = wd;
        if (whi) exp_hi = wd;
        if (wlo) exp_lo = wd;
        step();
        start_mult = 1'b0; start_div = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op_a = $urandom; op_b = $urandom;
        if (is_div && b == 32'd0) begin
            check("dz_done", done, 1);
            check("dz_flag", div_zero, 1);
            check("dz_busy", busy, 0);
            check("dz_nostart", div_start, 0);
            check("dz_hi", hi, exp_hi);
            check("dz_lo", lo, exp_lo);
            step();
            check("dz_pulse", {done, div_zero}, 0);
            return;
        end
        check("issue_busy", busy, 1);
        check("issue_done", done, 0);
        check("issue_start", {mult_start, div_start}, is_div ? 2'b01 : 2'b10);
        check("issue_a", unit_a, a);
        check("issue_b", unit_b, b);
        check("issue_hilo", {hi, lo}, {exp_hi, exp_lo});
        step();
        check("start_1cyc", {mult_start, div_start}, 0);
        if (is_div) begin
            qa = $signed(a); qb = $signed(b);
            rh = 32'(qa % qb); rl = 32'(qa / qb);
            div_done = 1'b0; mult_done = 1'b1; mult_hi = $urandom; mult_lo = $urandom;
        end else begin
            p = longint'($signed(a)) * longint'($signed(b));
            rh = p[63:32]; rl = p[31:0];
            mult_done = 1'b0; div_done = 1'b1; div_hi = $urandom; div_lo = $urandom;
        end
        for (int i = 0; i < lat; i++) begin
            if (busy_wr && i == 0) begin mthi = 1'b1; wdata = 32'h1234; end
            step();
            mthi = 1'b0;
            check("wait_busy", busy, 1);
            check("wait_nodone", done, 0);
            check("wait_hi", hi, exp_hi);
        end
        if (is_div) begin div_done = 1'b1; div_hi = rh; div_lo = rl; end
        else begin mult_done = 1'b1; mult_hi = rh; mult_lo = rl; end
        exp_hi = rh; exp_lo = rl;
        step();
        check("cmt_done", done, 1);
        check("cmt_busy", busy, 0);
        check("cmt_hi", hi, exp_hi);
        check("cmt_lo", lo, exp_lo);
        check("cmt_flags", {div_zero, timeout}, 0);
        step();
        check("done_1cyc", done, 0);
    endtask

    task automatic do_mt(input bit whi, input bit wlo, input logic [31:0] wd);
        mthi = whi; mtlo = wlo; wdata = wd;
        if (whi) exp_hi = wd;
        if (wlo) exp_lo = wd;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
        check("mt_idle", {busy, done}, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          kind;
        int          n;
        reset = 1'b1;
        step(); step();
        check("rst_hilo", {hi, lo}, 0);
        check("rst_units", {unit_a, unit_b}, 0);
        check("rst_flags", {mult_start, div_start, busy, done, div_zero, timeout}, 0);
        reset = 1'b0;
        step();

        run_op(0, 0, 32'd7, 32'hFFFFFFFD, 32, 0, 0, 0, 0);
        check("t1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(0, 0, 32'd5, 32'd6, 32, 0, 0, 0, 0);
        run_op(1, 0, 32'd100, 32'd7, 10, 0, 0, 0, 0);
        check("t3_hilo", {hi, lo}, {32'd2, 32'd14});
        run_op(1, 0, 32'd55, 32'd0, 0, 0, 0, 0, 0);
        check("t3_dz_hilo", {hi, lo}, {32'd2, 32'd14});
        run_op(0, 0, 32'd3, 32'd9, 5, 0, 0, 0, 1);
        do_mt(0, 1, 32'h55);
        check("t4_lo", lo, 32'h55);
        run_op(0, 1, 32'hFFFF0000, 32'h12345, 4, 0, 0, 0, 0);
        do_mt(1, 1, 32'hCAFEF00D);
        run_op(0, 0, 32'd11, 32'd13, 3, 1, 1, 32'hDEAD, 0);

        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 4));
            ra = $urandom; rb = $urandom;
            if (kind == 2 && $urandom_range(0, 3) == 0) rb = 32'd0;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            case (kind)
                0, 1:    run_op(0, kind == 1, ra, rb, int'($urandom_range(1, 8)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
                2, 3:    run_op(1, 0, ra, rb, int'($urandom_range(1, 8)),
                                1'($urandom_range(0, 1)), 0, $urandom, 0);
                default: do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            endcase
        end

        start_mult = 1'b1; op_a = 32'd9; op_b = 32'd9;
        step();
        start_mult = 1'b0;
        step();
        mult_done = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("mrst_hilo", {hi, lo}, 0);
        check("mrst_state", {busy, done, mult_start, unit_a}, 0);
        mult_done = 1'b1; mult_hi = 32'hAAAA5555; mult_lo = 32'h5555AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrst_ignore", {hi, lo, 31'd0, done}, 0);
        end

`ifdef HILO_TIMEOUT_EN
        start_mult = 1'b1; op_a = 32'd2; op_b = 32'd3;
        step();
        start_mult = 1'b0;
        step();
        mult_done = 1'b0;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (done) begin n = i; break; end
        end
        check("to_cycles", n, 64);
        check("to_flag", timeout, 1);
        check("to_hilo", {hi, lo}, {exp_hi, exp_lo});
        check("to_busy", busy, 0);
        step();
        check("to_pulse", {done, timeout}, 0);
`else
        n = 0;
        check("no_to", {31'd0, timeout}, n);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
